// File: rtl/seq_booth_divider.sv
// Signed radix-2 restoring divider, one quotient bit per clock; done pulses WIDTH+2 edges after accept (2 on divide-by-zero).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
module seq_booth_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  prem;
  logic [WIDTH-1:0] qsh;
  logic [WIDTH-1:0] dvs_mag;
  logic            sgn_dvd, sgn_dvs, dz;
  logic            accept;
  logic [WIDTH:0]  shifted;
  logic [WIDTH:0]  trial;

  assign accept  = start && (state == IDLE || state == DONE);
  assign busy    = (state == RUN) || (state == FIX);
  assign done    = (state == DONE);
  // Partial remainder is one bit wider than the operands so 2^(WIDTH-1) magnitudes never overflow.
  assign shifted = {prem[WIDTH-1:0], qsh[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (divisor == '0) ? FIX : RUN;
        else        state_nxt = IDLE;
      end
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      prem        <= '0;
      qsh         <= '0;
      dvs_mag     <= '0;
      sgn_dvd     <= 1'b0;
      sgn_dvs     <= 1'b0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      qsh         <= dividend[WIDTH-1] ? -dividend : dividend;
      dvs_mag     <= divisor[WIDTH-1] ? -divisor : divisor;
      sgn_dvd     <= dividend[WIDTH-1];
      sgn_dvs     <= divisor[WIDTH-1];
      dz          <= (divisor == '0);
      prem        <= '0;
      cnt         <= CW'(WIDTH);
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
      if (!trial[WIDTH]) begin
        prem <= trial;
        qsh  <= {qsh[WIDTH-2:0], 1'b1};
      end else begin
        prem <= shifted;
        qsh  <= {qsh[WIDTH-2:0], 1'b0};
      end
    end else if (state == FIX) begin
      // On divide-by-zero qsh still holds the untouched dividend magnitude.
      if (dz) begin
        quotient    <= '1;
        remainder   <= sgn_dvd ? -qsh : qsh;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= (sgn_dvd ^ sgn_dvs) ? -qsh : qsh;
        remainder   <= sgn_dvd ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
      end
    end
  end

endmodule

// File: doc/seq_booth_divider.md
Name: seq_booth_divider

Overview:
- Multi-cycle signed integer divider; the inverse of the team's combinational Booth multiplier.
- Intended use: verify that multiplier products round-trip, and serve the datapath where a combinational divider is too large.
- Works on operand magnitudes with a radix-2 restoring shift/subtract loop, one quotient bit per clock.
- Applies sign correction at the end and reports results through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (two's complement; >= 4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a rising edge only when not busy.
- dividend  input  WIDTH  signed dividend; captured on the accepting edge.
- divisor  input  WIDTH  signed divisor; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign equals dividend sign, or zero.
- div_by_zero  output  1  set with done when divisor was 0; held until next accept.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, FSM=IDLE, counter=0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE/DONE + start=1, at edge E0:
  - Capture magnitudes |dividend| and |divisor| and both sign bits.
  - Clear the partial remainder; load counter=WIDTH.
  - busy=1, done=0, div_by_zero=0.
  - Go to RUN; if divisor==0, go to FIX directly.
- RUN, each edge:
  - Shift {partial_rem, dividend_mag} left 1.
  - Trial-subtract divisor_mag (WIDTH+1-bit subtract).
  - If non-negative, keep the difference and set the quotient LSB=1; else restore and set LSB=0.
  - Decrement counter; when it reaches 0 (after WIDTH iterations), go to FIX.
- FIX, one edge:
  - quotient = negate magnitude quotient if sign(dividend) XOR sign(divisor).
  - remainder = negate magnitude remainder if sign(dividend).
  - Register both outputs; done=1, busy=0; go to DONE.
- DONE: lasts one cycle; done returns to 0 at the next edge unless a new start is accepted there. Outputs hold.
- Latency:
  - Normal: done high in the cycle after edge E(WIDTH+1), i.e. WIDTH+2 edges from E0 including it.
  - Divide-by-zero: done high after edge E1.
- Divide-by-zero result: quotient = all ones (-1), remainder = dividend as captured, div_by_zero=1.
- Most-negative / -1 (e.g. -2^31 / -1): quotient = most-negative value (wraps), remainder=0, no flag. Magnitude arithmetic must be WIDTH+1 bits wide internally so |−2^(WIDTH-1)| is represented exactly.
- Rounding: results must equal Verilog signed / and % for all non-zero divisors.
- start while busy: ignored; the operation in flight is unaffected and inputs are not re-sampled.
- start in the same cycle done is high: accepted; done drops next cycle, busy rises.
- Operand inputs may change freely after E0.
- quotient/remainder are updated only at FIX (or at the div-by-zero path); they hold the previous result during RUN.
- rst asserted mid-operation: immediate return to reset values; no done pulse for the aborted operation.

Test Plan:
- 100 / 7 after reset -> busy high for 33 cycles, done pulses once in the 34th cycle after E0; quotient=14, remainder=2, div_by_zero=0.
- Sign combinations:
  - -100 / 7 -> q=-14, r=-2.
  - 100 / -7 -> q=-14, r=2.
  - -100 / -7 -> q=14, r=-2.
- Edge values:
  - 0x80000000 / -1 -> q=0x80000000, r=0.
  - 0x7FFFFFFF / 1 -> q=0x7FFFFFFF, r=0.
  - 5 / 9 -> q=0, r=5.
- 1234 / 0 -> done after E1, q=0xFFFFFFFF, r=1234, div_by_zero=1. A following 9/3 clears the flag and gives q=3, r=0.
- Handshake:
  - start held high continuously with changing operands -> back-to-back divisions using only operands present at each accepting edge.
  - start pulsed mid-RUN -> ignored.
- Assert rst at cycle 10 of a division -> busy=0, done never pulses, outputs 0. A fresh 50/5 afterwards -> q=10, r=0.
- Random regression: 10k random signed pairs (nonzero divisor) checked against / and %. Also check q*divisor + r == dividend via the existing Booth multiplier.
